// File: rtl/video_scanline_mixer.sv
// rtl/video_scanline_mixer.sv - native-depth RGB to 8-bit VGA output stage with scanlines
module video_scanline_mixer #(
    parameter int DW          = 8,
    parameter int LINE_W      = 11,
    parameter int BLANK_BLACK = 1
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ce_pix,
    input  logic [DW-1:0]     r,
    input  logic [DW-1:0]     g,
    input  logic [DW-1:0]     b,
    input  logic              mono,
    input  logic              HSync,
    input  logic              VSync,
    input  logic              HBlank,
    input  logic              VBlank,
    input  logic [3:0]        sl_level,
    input  logic              sl_phase,
    output logic              ce_pix_out,
    output logic [7:0]        VGA_R,
    output logic [7:0]        VGA_G,
    output logic [7:0]        VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_DE,
    output logic [LINE_W-1:0] line_cnt
);

    logic [7:0] r8, g8, b8;

    generate
        if (DW == 8) begin : g_full
            logic unused_mono;
            assign unused_mono = mono;
            assign r8 = r;
            assign g8 = g;
            assign b8 = b;
        end else if (DW == 4) begin : g_nibble
            assign r8 = mono ? {g, r} : {r, r};
            assign g8 = mono ? {g, r} : {g, g};
            assign b8 = mono ? {g, r} : {b, b};
        end else begin : g_replicate
            logic unused_mono;
            assign unused_mono = mono;
            assign r8 = {r, r[DW-1 -: 8-DW]};
            assign g8 = {g, g[DW-1 -: 8-DW]};
            assign b8 = {b, b[DW-1 -: 8-DW]};
        end
    endgenerate

    // Stage 1 keeps the scanline controls alongside the pixel so a mid-line change hits exactly one pixel.
    logic [7:0]        r1, g1, b1;
    logic              hs1, vs1, hde1, vde1, ce1, ph1;
    logic [3:0]        lvl1;
    logic              hs_d, vs_d, hde_d;
    logic              flag;
    logic              frame_valid;
    logic [LINE_W-1:0] run_cnt;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r1    <= '0;
            g1    <= '0;
            b1    <= '0;
            hs1   <= 1'b0;
            vs1   <= 1'b0;
            hde1  <= 1'b0;
            vde1  <= 1'b0;
            ce1   <= 1'b0;
            ph1   <= 1'b0;
            lvl1  <= '0;
            hs_d  <= 1'b0;
            vs_d  <= 1'b0;
            hde_d <= 1'b0;
        end else begin
            r1    <= r8;
            g1    <= g8;
            b1    <= b8;
            hs1   <= HSync;
            vs1   <= VSync;
            hde1  <= ~HBlank;
            vde1  <= ~VBlank;
            ce1   <= ce_pix;
            ph1   <= sl_phase;
            lvl1  <= sl_level;
            hs_d  <= hs1;
            vs_d  <= vs1;
            hde_d <= hde1;
        end
    end

    function automatic logic [7:0] atten(input logic [7:0] c, input logic [3:0] lvl);
        logic [11:0] p;
        p = 12'(c) * 12'(5'd16 - {1'b0, lvl});
        return p[11:4];
    endfunction

    logic       hs_fall, vs_fall, hde_rise, hde_fall, counted;
    logic       flag_nx, de_nx, dim, blank;
    logic [7:0] r_o, g_o, b_o;

    assign hs_fall  = hs_d & ~hs1;
    assign vs_fall  = vs_d & ~vs1;
    assign hde_rise = hde1 & ~hde_d;
    assign hde_fall = ~hde1 & hde_d;
    assign counted  = hde_rise & vde1;

    // The new parity applies to the first pixel of the new line, hence the combinational next value.
    assign flag_nx = vs_fall ? ph1 : (hs_fall ? ~flag : flag);
    assign de_nx   = hde_rise ? vde1 : (hde_fall ? 1'b0 : VGA_DE);
    assign dim     = flag_nx && (lvl1 != 4'd0);
    assign blank   = (BLANK_BLACK != 0) && !de_nx;

    assign r_o = blank ? 8'd0 : (dim ? atten(r1, lvl1) : r1);
    assign g_o = blank ? 8'd0 : (dim ? atten(g1, lvl1) : g1);
    assign b_o = blank ? 8'd0 : (dim ? atten(b1, lvl1) : b1);

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_HS      <= 1'b0;
            VGA_VS      <= 1'b0;
            VGA_DE      <= 1'b0;
            ce_pix_out  <= 1'b0;
            flag        <= 1'b0;
            frame_valid <= 1'b0;
            run_cnt     <= '0;
            line_cnt    <= '0;
        end else begin
            VGA_R      <= r_o;
            VGA_G      <= g_o;
            VGA_B      <= b_o;
            VGA_HS     <= hs1;
            VGA_VS     <= vs1;
            VGA_DE     <= de_nx;
            ce_pix_out <= ce1;
            flag       <= flag_nx;
            // A frame only publishes once it started on a VS fall seen since reset.
            if (vs_fall) begin
                if (frame_valid) line_cnt <= run_cnt;
                frame_valid <= 1'b1;
                run_cnt     <= counted ? LINE_W'(1) : '0;
            end else if (counted && run_cnt != '1) begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_video_scanline_mixer.sv
// tb/tb_video_scanline_mixer.sv - randomized model-checked bench for video_scanline_mixer
module tb_video_scanline_mixer;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic       reset_n, ce_pix, mono, hs, vs, hb, vb, sl_phase;
    logic [3:0] sl_level;
    logic [7:0] r, g, b;

    logic        ce_o8, hs_o8, vs_o8, de_o8;
    logic [7:0]  r_o8, g_o8, b_o8;
    logic [10:0] lc8;
    logic        ce_o4, hs_o4, vs_o4, de_o4;
    logic [7:0]  r_o4, g_o4, b_o4;
    logic [3:0]  lc4;

    video_scanline_mixer #(.DW(8), .LINE_W(11), .BLANK_BLACK(1)) dut8 (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix),
        .r(r), .g(g), .b(b), .mono(mono),
        .HSync(hs), .VSync(vs), .HBlank(hb), .VBlank(vb),
        .sl_level(sl_level), .sl_phase(sl_phase),
        .ce_pix_out(ce_o8), .VGA_R(r_o8), .VGA_G(g_o8), .VGA_B(b_o8),
        .VGA_HS(hs_o8), .VGA_VS(vs_o8), .VGA_DE(de_o8), .line_cnt(lc8)
    );

    video_scanline_mixer #(.DW(4), .LINE_W(4), .BLANK_BLACK(0)) dut4 (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix),
        .r(r[7:4]), .g(g[7:4]), .b(b[7:4]), .mono(mono),
        .HSync(hs), .VSync(vs), .HBlank(hb), .VBlank(vb),
        .sl_level(sl_level), .sl_phase(sl_phase),
        .ce_pix_out(ce_o4), .VGA_R(r_o4), .VGA_G(g_o4), .VGA_B(b_o4),
        .VGA_HS(hs_o4), .VGA_VS(vs_o4), .VGA_DE(de_o4), .line_cnt(lc4)
    );

    typedef struct {
        logic [7:0] r8, g8, b8, r4, g4, b4;
        logic       hs, vs, de, ce;
        int         lc8, lc4;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: sync history, line parity, DE, and per-frame line tallies.
    bit m_hs, m_vs, m_hde, m_dark, m_de, m_valid;
    int m_run8, m_run4, m_lc8, m_lc4;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] darken(input logic [7:0] c, input bit dark, input logic [3:0] lvl);
        if (dark && lvl != 0) return 8'((int'(c) * (16 - int'(lvl))) / 16);
        return c;
    endfunction

    task automatic model_reset();
        exp_t z;
        z = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        q.delete();
        q.push_back(z);
        q.push_back(z);
        m_hs = 0; m_vs = 0; m_hde = 0; m_dark = 0; m_de = 0; m_valid = 0;
        m_run8 = 0; m_run4 = 0; m_lc8 = 0; m_lc4 = 0;
    endtask

    task automatic model_step();
        exp_t e;
        bit   hde, vde, counted;
        logic [7:0] c4r, c4g, c4b;
        hde = !hb;
        vde = !vb;
        if (m_vs && !vs)      m_dark = sl_phase;
        else if (m_hs && !hs) m_dark = !m_dark;
        if (hde && !m_hde)      m_de = vde;
        else if (!hde && m_hde) m_de = 0;
        counted = hde && !m_hde && vde;
        if (m_vs && !vs) begin
            if (m_valid) begin m_lc8 = m_run8; m_lc4 = m_run4; end
            m_valid = 1;
            m_run8 = counted ? 1 : 0;
            m_run4 = counted ? 1 : 0;
        end else if (counted) begin
            if (m_run8 < 2047) m_run8++;
            if (m_run4 < 15)   m_run4++;
        end
        c4r = mono ? {g[7:4], r[7:4]} : {r[7:4], r[7:4]};
        c4g = mono ? {g[7:4], r[7:4]} : {g[7:4], g[7:4]};
        c4b = mono ? {g[7:4], r[7:4]} : {b[7:4], b[7:4]};
        e.r8 = m_de ? darken(r, m_dark, sl_level) : 8'd0;
        e.g8 = m_de ? darken(g, m_dark, sl_level) : 8'd0;
        e.b8 = m_de ? darken(b, m_dark, sl_level) : 8'd0;
        e.r4 = darken(c4r, m_dark, sl_level);
        e.g4 = darken(c4g, m_dark, sl_level);
        e.b4 = darken(c4b, m_dark, sl_level);
        e.hs = hs; e.vs = vs; e.de = m_de; e.ce = ce_pix;
        e.lc8 = m_lc8; e.lc4 = m_lc4;
        q.push_back(e);
        m_hs = hs; m_vs = vs; m_hde = hde;
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk_sys);
        #1;
        if (q.size() == 2) begin
            e = q.pop_front();
            check_eq("R8", r_o8, e.r8);
            check_eq("G8", g_o8, e.g8);
            check_eq("B8", b_o8, e.b8);
            check_eq("HS8", hs_o8, e.hs);
            check_eq("VS8", vs_o8, e.vs);
            check_eq("DE8", de_o8, e.de);
            check_eq("CE8", ce_o8, e.ce);
            check_eq("LC8", lc8, e.lc8);
            check_eq("R4", r_o4, e.r4);
            check_eq("G4", g_o4, e.g4);
            check_eq("B4", b_o4, e.b4);
            check_eq("HS4", hs_o4, e.hs);
            check_eq("VS4", vs_o4, e.vs);
            check_eq("DE4", de_o4, e.de);
            check_eq("CE4", ce_o4, e.ce);
            check_eq("LC4", lc4, e.lc4);
        end
    endtask

    function automatic logic [7:0] pick_colour();
        case ($urandom_range(0, 3))
            0:       return 8'd255;
            1:       return 8'd200;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic pix(input bit h, input bit v, input bit hbl, input bit vbl);
        tick();
        reset_n = 1'b1;
        hs = h; vs = v; hb = hbl; vb = vbl;
        r = pick_colour(); g = pick_colour(); b = pick_colour();
        ce_pix = 1'($urandom);
        mono   = 1'($urandom);
        if ($urandom_range(0, 15) == 0) sl_level = 4'($urandom);
        if ($urandom_range(0, 63) == 0) sl_phase = 1'($urandom);
        model_step();
    endtask

    task automatic do_line(input int line);
        for (int px = 0; px < 20; px++)
            pix(px < 2, line < 3, px < 4, line < 38);
    endtask

    initial begin
        reset_n = 1'b0; ce_pix = 0; mono = 0; hs = 0; vs = 0; hb = 0; vb = 0;
        sl_phase = 0; sl_level = 4'd8; r = 0; g = 0; b = 0;
        model_reset();
        for (int f = 0; f < 2; f++)
            for (int ln = 0; ln < 262; ln++) do_line(ln);
        check_eq("LC8_FRAME", lc8, 224);
        check_eq("LC4_SAT", lc4, 15);

        for (int ln = 0; ln < 5; ln++) do_line(ln);
        for (int px = 0; px < 10; px++) pix(px < 2, 1'b0, px < 4, 1'b0);
        tick();
        reset_n = 1'b0;
        model_reset();
        tick();
        check_eq("RST_LC8", lc8, 0);
        check_eq("RST_DE8", de_o8, 0);
        reset_n = 1'b1;
        model_step();
        for (int ln = 5; ln < 60; ln++) do_line(ln);

        for (int i = 0; i < 3000; i++)
            pix(($urandom_range(0, 5) == 0) ? !hs : hs,
                ($urandom_range(0, 7) == 0) ? !vs : vs,
                ($urandom_range(0, 4) == 0) ? !hb : hb,
                ($urandom_range(0, 9) == 0) ? !vb : vb);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
